mac_accumulator: RTL

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_pkg.sv | 7 +
 rtl/mac_sat_adder.sv | 25 ++
 rtl/mac_accumulator.sv | 81 ++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM state encoding and default widths for the MAC accumulator
package mac_pkg;
  localparam int DEF_PROD_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 16;
  localparam int DEF_LEN_WIDTH  = 8;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;
endpackage

// File: rtl/mac_sat_adder.sv
// mac_sat_adder: combinational saturating adder, signed or unsigned
// Ports: i_a, i_b   operands, already extended to W bits by the caller
//        i_sign     1 = two's complement, 0 = unsigned
//        o_sum      saturated sum
//        o_sat      the exact sum was out of range and was clamped
module mac_sat_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sign,
  output logic [W-1:0] o_sum,
  output logic         o_sat
);
  logic [W:0] w_raw;
  logic       w_s_ovf;
  assign w_raw   = {1'b0, i_a} + {1'b0, i_b};
  // signed overflow: operands agree in sign but the result does not
  assign w_s_ovf = (i_a[W-1] == i_b[W-1]) && (w_raw[W-1] != i_a[W-1]);
  assign o_sat   = i_sign ? w_s_ovf : w_raw[W];
  // signed clamp direction follows the common operand sign
  assign o_sum   = !o_sat ? w_raw[W-1:0] :
                   !i_sign ? {W{1'b1}} :
                   i_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates Length products with saturation, then holds the result
// Ports: i_clk/i_rst        clock, async active-high reset
//        i_start/i_length/i_sign  begin a run (IDLE only), term count, signedness
//        i_abort            synchronous cancel from any state
//        i_product/i_in_valid/o_in_ready  product input handshake
//        o_acc_out/o_overflow/o_out_valid/i_out_ready  result handshake
//        o_busy             not in IDLE
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_length,
  input  logic                  i_sign,
  input  logic                  i_abort,
  input  logic [PROD_WIDTH-1:0] i_product,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic [ACC_WIDTH-1:0]  o_acc_out,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_overflow,
  output logic                  o_busy
);
  state_t                r_state, w_next;
  logic [ACC_WIDTH-1:0]  r_acc, w_ext, w_sum;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_sign, r_ovf, w_sat, w_xfer, w_begin;
  assign w_xfer  = (r_state == S_ACCUM) && i_in_valid;
  assign w_begin = (r_state == S_IDLE) && i_start;
  assign w_ext   = r_sign ? {{(ACC_WIDTH-PROD_WIDTH){i_product[PROD_WIDTH-1]}}, i_product}
                          : {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, i_product};
  mac_sat_adder #(.W(ACC_WIDTH)) u_add (
    .i_a    (r_acc),
    .i_b    (w_ext),
    .i_sign (r_sign),
    .o_sum  (w_sum),
    .o_sat  (w_sat)
  );
  always_comb begin
    w_next = i_abort ? S_IDLE :
             w_begin ? (i_length == '0 ? S_HOLD : S_ACCUM) :
             (w_xfer && r_cnt == LEN_WIDTH'(1)) ? S_HOLD :
             (r_state == S_HOLD && i_out_ready) ? S_IDLE : r_state;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_sign <= 1'b0;
    end else if (i_abort) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_begin) begin
      r_acc  <= '0;
      r_cnt  <= i_length;
      r_ovf  <= 1'b0;
      r_sign <= i_sign;
    end else if (w_xfer) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt - LEN_WIDTH'(1);
      r_ovf <= r_ovf | w_sat;
    end
  end
  assign o_acc_out   = r_acc;
  assign o_overflow  = r_ovf;
  assign o_in_ready  = r_state == S_ACCUM;
  assign o_out_valid = r_state == S_HOLD;
  assign o_busy      = r_state != S_IDLE;
endmodule
